uart_rx_frame_check: RTL

Serial-domain successor to the receive-side parity checker. It consumes validated bit samples from the RX sampler one strobe at a time and assembles a frame: start, N data bits (LSB first), optional parity, one or two stop bits. Parity is accumulated on the fly and checked against the received parity bit, and stop bits are checked for framing errors. It reports per-frame data and error flags plus saturating error counters. It sits between the RX bit sampler and the RX FSM/output register.

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_frame_check_sat_counter.sv | 22 ++
 rtl/uart_rx_frame_check.sv | 134 +++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive frame checker: FSM state encoding
// and parity-type codes.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_t;

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_frame_check_sat_counter.sv
// Saturating up-counter used for the per-frame error tallies; clear beats increment.
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/uart_rx_frame_check.sv
// Assembles a UART frame from sampler strobes, checks parity and stop bits,
// and keeps saturating error counters.
module uart_rx_frame_check #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  par_en,
    input  logic                  par_type,
    input  logic                  stop2,
    input  logic                  frm_start,
    input  logic                  smp_valid,
    input  logic                  smp_bit,
    input  logic                  clr_cnt,
    output logic                  frame_done,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  par_err,
    output logic                  stop_err,
    output logic [CNT_WIDTH-1:0]  par_err_cnt,
    output logic [CNT_WIDTH-1:0]  stop_err_cnt,
    output logic [1:0]            dbg_state
);
    import uart_pkg::*;

    // Handshake: one sample is consumed per cycle with smp_valid high; a
    // frm_start in the same cycle wins and that sample is dropped.
    localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);

    state_t                state;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [3:0]            bit_cnt;
    logic                  par_acc;
    logic                  par_err_acc;
    logic                  stop_err_acc;
    logic                  stop_cnt;
    logic                  cfg_par_en;
    logic                  cfg_par_type;
    logic                  cfg_stop2;

    logic last_strobe;
    logic stop_bad;
    logic par_flag;

    always_comb begin
        last_strobe = 1'b0;
        stop_bad    = stop_err_acc | ~smp_bit;
        par_flag    = cfg_par_en & par_err_acc;
        if (smp_valid && !frm_start && (state == STOP) && (stop_cnt == cfg_stop2)) begin
            last_strobe = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state        <= IDLE;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            par_acc      <= 1'b0;
            par_err_acc  <= 1'b0;
            stop_err_acc <= 1'b0;
            stop_cnt     <= 1'b0;
            cfg_par_en   <= 1'b0;
            cfg_par_type <= 1'b0;
            cfg_stop2    <= 1'b0;
            frame_done   <= 1'b0;
            rx_data      <= '0;
            par_err      <= 1'b0;
            stop_err     <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (frm_start) begin
                // Restart from any state; an interrupted frame leaves no trace.
                state        <= DATA;
                cfg_par_en   <= par_en;
                cfg_par_type <= par_type;
                cfg_stop2    <= stop2;
                shift_reg    <= '0;
                bit_cnt      <= '0;
                par_acc      <= 1'b0;
                par_err_acc  <= 1'b0;
                stop_err_acc <= 1'b0;
                stop_cnt     <= 1'b0;
            end else if (smp_valid) begin
                case (state)
                    DATA: begin
                        shift_reg <= {smp_bit, shift_reg[DATA_WIDTH-1:1]};
                        par_acc   <= par_acc ^ smp_bit;
                        bit_cnt   <= bit_cnt + 4'd1;
                        if (bit_cnt == LAST_BIT) begin
                            state <= cfg_par_en ? PARITY : STOP;
                        end
                    end
                    PARITY: begin
                        par_err_acc <= smp_bit != (par_acc ^ (cfg_par_type == PAR_ODD));
                        state       <= STOP;
                    end
                    STOP: begin
                        if (last_strobe) begin
                            state      <= IDLE;
                            frame_done <= 1'b1;
                            rx_data    <= shift_reg;
                            par_err    <= par_flag;
                            stop_err   <= stop_bad;
                        end else begin
                            stop_err_acc <= stop_bad;
                            stop_cnt     <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign dbg_state = state;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_par_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (last_strobe & par_flag),
        .clr   (clr_cnt),
        .count (par_err_cnt)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_stop_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (last_strobe & stop_bad),
        .clr   (clr_cnt),
        .count (stop_err_cnt)
    );

endmodule
